// File: rtl/msadc_pkg.sv
// Shared types and constants for the multislope ADC sequencer.
package msadc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRunup,
        StSettle,
        StRundown,
        StResult,
        StReset
    } state_e;

    // Bit positions inside the packed switch vector {in, up, dn, rst, vref}
    localparam int unsigned SwIn   = 4;
    localparam int unsigned SwUp   = 3;
    localparam int unsigned SwDn   = 2;
    localparam int unsigned SwRst  = 1;
    localparam int unsigned SwVref = 0;

    localparam logic [4:0] SwPatIdle  = 5'b00011;  // integrator shorted, vref on
    localparam logic [4:0] SwPatOff   = 5'b00000;
    localparam logic [4:0] SwPatRunup = 5'b10001;  // input + vref, slope bits added per tick

    // Bit positions inside res_flags
    localparam int unsigned FlagZero = 2;
    localparam int unsigned FlagDrop = 1;
    localparam int unsigned FlagSat  = 0;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msadc_rundown_timer.sv
// Comparator synchroniser plus the gated, saturating clk-rate run-down counter.
// arm latches the run-down polarity from the synchronised comparator and clears the count.
module msadc_rundown_timer
    import msadc_pkg::*;
#(
    parameter int unsigned RUNDOWN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 comp_n,
    input  logic                 arm,
    input  logic                 run,
    output logic                 comp,
    output logic                 sign,
    output logic [RUNDOWN_W-1:0] count,
    output logic                 sat
);

    logic sync1_q, sync2_q;
    logic gate_q;

    assign comp = sync2_q;

    // Two-flop synchroniser for the asynchronous, active-low comparator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~comp_n;
            sync2_q <= sync1_q;
        end
    end

    // Count while the comparator still agrees with the polarity; first disagreement freezes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign   <= 1'b0;
            count  <= '0;
            sat    <= 1'b0;
            gate_q <= 1'b0;
        end else if (arm) begin
            sign   <= comp;
            count  <= '0;
            sat    <= 1'b0;
            gate_q <= 1'b1;
        end else if (run && gate_q) begin
            if (comp != sign) begin
                gate_q <= 1'b0;
            end else if (&count) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/msadc_sequencer.sv
// Multislope integrating-ADC sequencer: prescaler, conversion FSM and result register.
// Optional build macro MSADC_AUTOZERO_EN alternates input and zero conversions.
module msadc_sequencer
    import msadc_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 40,
    parameter int unsigned PERIOD        = 100,
    parameter int unsigned MINOR         = 10,
    parameter int unsigned RESET_TICKS   = 4000,
    parameter int unsigned SETTLE_TICKS  = 20,
    parameter int unsigned RUNDOWN_TICKS = 1200,
    parameter int unsigned RUNUP_W       = 15,
    parameter int unsigned RUNDOWN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_en,
    input  logic                 comp_n,
    input  logic [RUNUP_W-1:0]   cfg_runup_len,
    output logic                 sw_in,
    output logic                 sw_up,
    output logic                 sw_dn,
    output logic                 sw_rst,
    output logic                 sw_vref,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RUNUP_W-1:0]   res_runup,
    output logic [RUNUP_W-1:0]   res_len,
    output logic                 res_sign,
    output logic [RUNDOWN_W-1:0] res_rundown,
    output logic [2:0]           res_flags,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned KW = $clog2(PERIOD);
    localparam int unsigned CW = $clog2(max3(RESET_TICKS, SETTLE_TICKS, RUNDOWN_TICKS) + 1);

    localparam logic [PW-1:0] PrescLast   = PW'(CLK_DIV - 1);
    localparam logic [KW-1:0] KLast       = KW'(PERIOD - 1);
    localparam logic [KW-1:0] KMinor      = KW'(MINOR);
    localparam logic [KW-1:0] KMajor      = KW'(PERIOD - MINOR);
    localparam logic [CW-1:0] SettleLast  = CW'(SETTLE_TICKS - 1);
    localparam logic [CW-1:0] RundownLast = CW'(RUNDOWN_TICKS - 1);
    localparam logic [CW-1:0] ResetLast   = CW'(RESET_TICKS - 1);

    state_e               state_q, state_d;
    logic [PW-1:0]        presc_q;
    logic [KW-1:0]        k_q;
    logic [RUNUP_W-1:0]   per_q, len_q, runup_q;
    logic                 d_q;
    logic [CW-1:0]        cnt_q;
    logic                 load_q;
    logic [4:0]           sw;

    logic                 tick, k_last, runup_done, runup_dn;
    logic                 settle_last, rundown_last, reset_last;
    logic                 start_conv, arm, zero_conv;
    logic                 comp, rd_sign, rd_sat;
    logic [RUNDOWN_W-1:0] rd_count;

    assign tick         = (presc_q == PrescLast);
    assign k_last       = (k_q == KLast);
    assign runup_done   = k_last && (per_q == len_q);
    assign settle_last  = (cnt_q == SettleLast);
    assign rundown_last = (cnt_q == RundownLast);
    assign reset_last   = (cnt_q == ResetLast);
    assign runup_dn     = d_q ? (k_q < KMinor) : (k_q < KMajor);
    assign start_conv   = tick && start_en &&
                          ((state_q == StIdle) || ((state_q == StReset) && reset_last));
    assign arm          = tick && start_en && (state_q == StSettle) && settle_last;
    assign busy         = (state_q != StIdle);

    assign {sw_in, sw_up, sw_dn, sw_rst, sw_vref} = sw;

    msadc_rundown_timer #(
        .RUNDOWN_W(RUNDOWN_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .comp_n(comp_n),
        .arm   (arm),
        .run   (state_q == StRundown),
        .comp  (comp),
        .sign  (rd_sign),
        .count (rd_count),
        .sat   (rd_sat)
    );

    // Free-running prescaler producing a one-clk tick every CLK_DIV clks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else if (tick) presc_q <= '0;
        else presc_q <= presc_q + 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else state_q <= state_d;
    end

    // Next state: moves only on tick, start_en low aborts from anywhere
    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (!start_en) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle:    state_d = StRunup;
                    StRunup:   if (runup_done) state_d = StSettle;
                    StSettle:  if (settle_last) state_d = StRundown;
                    StRundown: if (rundown_last) state_d = StResult;
                    StResult:  state_d = StReset;
                    StReset:   if (reset_last) state_d = StRunup;
                    default:   state_d = StIdle;
                endcase
            end
        end
    end

    // Switch outputs decoded from state; up/dn are complements so never both high
    always_comb begin
        sw = SwPatIdle;
        unique case (state_q)
            StRunup: begin
                sw        = SwPatRunup;
                sw[SwIn]  = ~zero_conv;
                sw[SwDn]  = runup_dn;
                sw[SwUp]  = ~runup_dn;
            end
            StSettle: sw = SwPatOff;
            StRundown: begin
                sw       = SwPatOff;
                sw[SwUp] = rd_sign;
                sw[SwDn] = ~rd_sign;
            end
            default: sw = SwPatIdle;
        endcase
    end

    // Run-up bookkeeping and tick counters for the timed states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            per_q   <= '0;
            len_q   <= '0;
            runup_q <= '0;
            d_q     <= 1'b0;
            cnt_q   <= '0;
        end else if (tick) begin
            if (start_conv) begin
                len_q   <= cfg_runup_len;
                k_q     <= '0;
                per_q   <= '0;
                runup_q <= '0;
                d_q     <= 1'b0;
            end else if (state_q == StRunup) begin
                if (k_last) begin
                    k_q <= '0;
                    // The final period (per_q == len_q) carries no decision
                    if (per_q != len_q) begin
                        d_q     <= comp;
                        runup_q <= runup_q + RUNUP_W'(comp);
                        per_q   <= per_q + 1'b1;
                    end
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
            case (state_q)
                StSettle:  cnt_q <= settle_last  ? '0 : cnt_q + 1'b1;
                StRundown: cnt_q <= rundown_last ? '0 : cnt_q + 1'b1;
                StReset:   cnt_q <= reset_last   ? '0 : cnt_q + 1'b1;
                default:   cnt_q <= '0;
            endcase
        end
    end

`ifdef MSADC_AUTOZERO_EN
    logic zero_q;

    // Alternate input/zero on back-to-back conversions; a start from idle is always input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_q <= 1'b0;
        else if (start_conv) zero_q <= (state_q == StReset) ? ~zero_q : 1'b0;
    end

    assign zero_conv = zero_q;
`else
    assign zero_conv = 1'b0;
`endif

    // Result register: load one clk after the RESULT tick, hold until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q      <= 1'b0;
            res_valid   <= 1'b0;
            res_runup   <= '0;
            res_len     <= '0;
            res_sign    <= 1'b0;
            res_rundown <= '0;
            res_flags   <= '0;
        end else begin
            load_q <= tick && start_en && (state_q == StResult);
            if (load_q) begin
                res_valid             <= 1'b1;
                res_runup             <= runup_q;
                res_len               <= len_q;
                res_sign              <= rd_sign;
                res_rundown           <= rd_count;
                res_flags[FlagZero]   <= zero_conv;
                // Concurrent accept consumes the old result, so it is not a drop
                res_flags[FlagDrop]   <= res_valid && !res_ready;
                res_flags[FlagSat]    <= rd_sat;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msadc_sequencer.sv
// Scoreboard bench for msadc_sequencer with small timing parameters.
module tb_msadc_sequencer;

    localparam int WRunup   = 0;
    localparam int WRundown = 1;
    localparam int WSwRst   = 2;
    localparam int WEmpty   = 3;
    localparam int WIdle    = 4;
    localparam int WDrop    = 5;

`ifdef MSADC_AUTOZERO_EN
    localparam logic AZ = 1'b1;
`else
    localparam logic AZ = 1'b0;
`endif

    typedef struct packed {
        logic [14:0] runup;
        logic [14:0] len;
        logic        sign;
        logic [15:0] rundown;
        logic [2:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_en = 1'b0;
    logic        start_b = 1'b0;
    logic        comp_n = 1'b1;
    logic        res_ready = 1'b1;
    logic [14:0] cfg = '0;

    logic        sw_in, sw_up, sw_dn, sw_rst, sw_vref, res_valid, res_sign, busy;
    logic [14:0] res_runup, res_len;
    logic [15:0] res_rundown;
    logic [2:0]  res_flags;

    logic        b_sw_in, b_sw_up, b_sw_dn, b_sw_rst, b_sw_vref, b_valid, b_sign, b_busy;
    logic [14:0] b_runup, b_len;
    logic [3:0]  b_rundown;
    logic [2:0]  b_flags;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   failures = 0;
    bit   cnt_en = 1'b0;
    int   dn_clks = 0, up_clks = 0, both_clks = 0;

    always #5 clk = ~clk;

    msadc_sequencer #(
        .CLK_DIV(4), .PERIOD(10), .MINOR(2), .RESET_TICKS(5), .SETTLE_TICKS(2),
        .RUNDOWN_TICKS(8), .RUNUP_W(15), .RUNDOWN_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start_en(start_en), .comp_n(comp_n), .cfg_runup_len(cfg),
        .sw_in(sw_in), .sw_up(sw_up), .sw_dn(sw_dn), .sw_rst(sw_rst), .sw_vref(sw_vref),
        .res_valid(res_valid), .res_ready(res_ready), .res_runup(res_runup),
        .res_len(res_len), .res_sign(res_sign), .res_rundown(res_rundown),
        .res_flags(res_flags), .busy(busy)
    );

    msadc_sequencer #(
        .CLK_DIV(4), .PERIOD(10), .MINOR(2), .RESET_TICKS(5), .SETTLE_TICKS(2),
        .RUNDOWN_TICKS(8), .RUNUP_W(15), .RUNDOWN_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .start_en(start_b), .comp_n(comp_n), .cfg_runup_len(cfg),
        .sw_in(b_sw_in), .sw_up(b_sw_up), .sw_dn(b_sw_dn), .sw_rst(b_sw_rst),
        .sw_vref(b_sw_vref), .res_valid(b_valid), .res_ready(1'b1), .res_runup(b_runup),
        .res_len(b_len), .res_sign(b_sign), .res_rundown(b_rundown), .res_flags(b_flags),
        .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic bit cond(input int what);
        case (what)
            WRunup:   return sw_in;
            WRundown: return !sw_in && (sw_up || sw_dn);
            WSwRst:   return sw_rst;
            WEmpty:   return (qa.size() == 0) && (qb.size() == 0);
            WIdle:    return !busy && !b_busy;
            WDrop:    return res_valid && res_flags[1];
            default:  return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cond(what)) return;
            n++;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL timeout_%s: got no event in %0d clks, required event", name, budget);
                return;
            end
        end
    endtask

    function automatic exp_t mk(input int ru, input int ln, input logic sg, input int rd,
                                input logic [2:0] fl);
        exp_t e;
        e.runup   = 15'(ru);
        e.len     = 15'(ln);
        e.sign    = sg;
        e.rundown = 16'(rd);
        e.flags   = fl;
        return e;
    endfunction

    // Monitor for the main instance: compare on every accepted result
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got rundown %0d, required none", res_rundown);
            end else begin
                ea = qa.pop_front();
                chk("res_runup", 32'(res_runup), 32'(ea.runup));
                chk("res_len", 32'(res_len), 32'(ea.len));
                chk("res_sign", 32'(res_sign), 32'(ea.sign));
                chk("res_rundown", 32'(res_rundown), 32'(ea.rundown));
                chk("res_flags", 32'(res_flags), 32'(ea.flags));
            end
        end
    end

    // Monitor for the narrow run-down instance
    always @(negedge clk) begin
        if (!rst && b_valid) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result_sat: got rundown %0d, required none", b_rundown);
            end else begin
                eb = qb.pop_front();
                chk("sat_runup", 32'(b_runup), 32'(eb.runup));
                chk("sat_sign", 32'(b_sign), 32'(eb.sign));
                chk("sat_rundown", 32'(b_rundown), 32'(eb.rundown));
                chk("sat_flags", 32'(b_flags), 32'(eb.flags));
            end
        end
    end

    // Run-up slope usage, counted in clks while the input switch is on
    always @(negedge clk) begin
        if (cnt_en) begin
            if (sw_in && sw_dn) dn_clks++;
            if (sw_in && sw_up) up_clks++;
            if (sw_up && sw_dn) both_clks++;
        end
    end

    initial begin
        int  n;
        bit  seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_sw", 32'({sw_in, sw_up, sw_dn, sw_rst, sw_vref}), 32'h03);
        chk("reset_valid", 32'(res_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rundown", 32'(res_rundown), 0);
        rst = 1'b0;

        // Asynchronous reset in the middle of run-up
        cfg = 15'd3;
        start_en = 1'b1;
        wait_for(WRunup, 20, "runup_entry");
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sw", 32'({sw_in, sw_up, sw_dn, sw_rst, sw_vref}), 32'h03);
        chk("midrst_valid", 32'(res_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        start_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Comparator high, len 3: three decisions, never crosses
        comp_n = 1'b0;
        cfg = 15'd3;
        qa.push_back(mk(3, 3, 1'b1, 32, 3'b000));
        qb.push_back(mk(3, 3, 1'b1, 15, 3'b001));
        cnt_en = 1'b1;
        start_en = 1'b1;
        start_b = 1'b1;
        wait_for(WRundown, 400, "rundown1");
        wait_for(WSwRst, 60, "result1");
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("result_latency", 32'(n), 5);
        wait_for(WEmpty, 50, "accept1");
        cnt_en = 1'b0;
        start_en = 1'b0;
        start_b = 1'b0;
        chk("runup_dn_clks", 32'(dn_clks), 56);
        chk("runup_up_clks", 32'(up_clks), 104);
        chk("runup_both_clks", 32'(both_clks), 0);
        wait_for(WIdle, 40, "idle1");

        // Comparator low, crossing 17 clks into run-down
        comp_n = 1'b1;
        cfg = 15'd1;
        qa.push_back(mk(0, 1, 1'b0, 17, 3'b000));
        start_en = 1'b1;
        wait_for(WRundown, 300, "rundown2");
        repeat (15) @(posedge clk);
        #1 comp_n = 1'b0;
        wait_for(WEmpty, 100, "accept2");
        start_en = 1'b0;
        wait_for(WIdle, 40, "idle2");

        // Two conversions with no consumer: second overwrites with drop
        cfg = 15'd0;
        res_ready = 1'b0;
        qa.push_back(mk(0, 0, 1'b1, 32, {AZ, 1'b1, 1'b0}));
        start_en = 1'b1;
        wait_for(WDrop, 600, "drop");
        start_en = 1'b0;
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("valid_clear", 32'(res_valid), 0);
        wait_for(WEmpty, 5, "accept3");
        wait_for(WIdle, 40, "idle3");

        // Abort during run-down: no result
        cfg = 15'd1;
        start_en = 1'b1;
        wait_for(WRundown, 300, "rundown4");
        start_en = 1'b0;
        wait_for(WIdle, 8, "abort_idle");
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 0);

        // Back-to-back conversions after the abort
        qa.push_back(mk(1, 1, 1'b1, 32, 3'b000));
        qa.push_back(mk(1, 1, 1'b1, 32, {AZ, 2'b00}));
        qa.push_back(mk(1, 1, 1'b1, 32, 3'b000));
        start_en = 1'b1;
        wait_for(WEmpty, 1500, "accept_seq");
        start_en = 1'b0;
        wait_for(WIdle, 40, "idle5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, required finish");
        $fatal(1, "watchdog");
    end

endmodule
